// File: rtl/tl_pkg.sv
// Shared constants for the traffic-light controller slice: the input debounce
// window and the 1 s tick timing, both derived from one clock frequency.
package tl_pkg;

  // System clock frequency; every timing constant below is derived from it.
  localparam int unsigned CLK_HZ = 100_000_000;

  // 10 ms debounce window at CLK_HZ.
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 100;
  localparam int unsigned DEBOUNCE_CNT_W_DEFAULT  = 20;

  // One-second tick used by the clock divider that produces one_sec_clk.
  localparam int unsigned ONE_SEC_TICKS = CLK_HZ;
  localparam int unsigned ONE_SEC_CNT_W = $clog2(ONE_SEC_TICKS);

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a stability counter. The output follows
// the synchronised input only after it has held a new level for
// DEBOUNCE_CYCLES consecutive cycles; any shorter excursion restarts the count.
module debounce_filter
  import tl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = DEBOUNCE_CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic in_raw,
  output logic out_stable
);

  // Terminal count; the counter never goes past it, so it cannot wrap.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_r;
  logic             s2_r;
  logic             stable_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronise the raw pin and count how long it has disagreed with stable_r.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r     <= 1'b0;
      s2_r     <= 1'b0;
      stable_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      s1_r <= in_raw;
      s2_r <= s1_r;
      if (s2_r == stable_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_MAX) begin
        stable_r <= s2_r;
        cnt_r    <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign out_stable = stable_r;

endmodule

// File: rtl/walk_sensor_conditioner.sv
// Conditions the raw walk button and side-street sensor for the traffic-light
// controller: debounced sensor level, plus a latched walk request that the
// controller clears with walkClear. A new press always wins over a clear.
module walk_sensor_conditioner
  import tl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = DEBOUNCE_CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic walkButton,
  input  logic sensor,
  input  logic walkClear,
  output logic walkRequest,
  output logic walkPressPulse,
  output logic sensorStable
);

  logic btn_stable_s;
  logic sensor_stable_s;
  logic btn_stable_d_r;
  logic press_s;
  logic walk_request_r;
  logic walk_press_pulse_r;

  debounce_filter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_btn_filter (
    .clk        (clk),
    .reset      (reset),
    .in_raw     (walkButton),
    .out_stable (btn_stable_s)
  );

  debounce_filter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_sensor_filter (
    .clk        (clk),
    .reset      (reset),
    .in_raw     (sensor),
    .out_stable (sensor_stable_s)
  );

  // Rising edge of the debounced button; releases produce nothing.
  always_comb begin
    press_s = btn_stable_s & ~btn_stable_d_r;
  end

  // Edge-detect history and the walk latch; set has priority over clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_stable_d_r     <= 1'b0;
      walk_request_r     <= 1'b0;
      walk_press_pulse_r <= 1'b0;
    end else begin
      btn_stable_d_r     <= btn_stable_s;
      walk_press_pulse_r <= press_s;
      if (press_s) begin
        walk_request_r <= 1'b1;
      end else if (walkClear) begin
        walk_request_r <= 1'b0;
      end else begin
        walk_request_r <= walk_request_r;
      end
    end
  end

  assign walkRequest    = walk_request_r;
  assign walkPressPulse = walk_press_pulse_r;
  assign sensorStable   = sensor_stable_s;

endmodule

// File: tb/tb_walk_sensor_conditioner.sv
// Directed bench for walk_sensor_conditioner with a 4-cycle debounce window.
// Tick numbering: after inputs change, tick 1 is the first sampling edge
// (edge 0), so a debounced level appears after tick 6 and a request after tick 7.
module tb_walk_sensor_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic walkButton;
  logic sensor;
  logic walkClear;
  logic walkRequest;
  logic walkPressPulse;
  logic sensorStable;

  int n_checks = 0;
  int n_fail   = 0;

  walk_sensor_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .walkButton     (walkButton),
    .sensor         (sensor),
    .walkClear      (walkClear),
    .walkRequest    (walkRequest),
    .walkPressPulse (walkPressPulse),
    .sensorStable   (sensorStable)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Run n ticks, counting walkPressPulse highs and walkRequest highs.
  task automatic run(input int n, output int pulses, output int reqs);
    pulses = 0;
    reqs   = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (walkPressPulse === 1'b1) pulses++;
      if (walkRequest === 1'b1) reqs++;
    end
  endtask

  initial begin
    int p;
    int r;
    int seen;

    // Reset with both raw inputs high
    reset = 1'b1; walkButton = 1'b1; sensor = 1'b1; walkClear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_walkRequest", int'(walkRequest), 0);
      check("rst_walkPressPulse", int'(walkPressPulse), 0);
      check("rst_sensorStable", int'(sensorStable), 0);
    end
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (sensorStable !== 1'b0) seen++;
    end
    check("sens_lat_early", seen, 0);
    tick();
    check("sens_lat_edge5", int'(sensorStable), 1);
    check("req_before_edge6", int'(walkRequest), 0);
    tick();
    check("req_edge6", int'(walkRequest), 1);
    check("pulse_edge6", int'(walkPressPulse), 1);
    run(10, p, r);
    check("held_single_press", p, 0);
    walkButton = 1'b0;
    run(10, p, r);
    check("release_no_pulse", p, 0);
    check("req_held_after_release", r, 10);
    walkClear = 1'b1;
    tick();
    walkClear = 1'b0;
    check("clear_latency", int'(walkRequest), 0);

    // Clean press, button held 20 cycles
    walkButton = 1'b1;
    run(6, p, r);
    check("clean_no_early_req", r, 0);
    tick();
    check("clean_req", int'(walkRequest), 1);
    check("clean_pulse", int'(walkPressPulse), 1);
    run(13, p, r);
    check("clean_single_pulse", p, 0);
    walkButton = 1'b0;
    run(10, p, r);
    check("clean_release_no_pulse", p, 0);
    check("clean_req_holds", r, 10);
    walkClear = 1'b1;
    tick();
    walkClear = 1'b0;
    check("clean_clear", int'(walkRequest), 0);
    walkClear = 1'b1;
    tick();
    walkClear = 1'b0;
    check("idle_clear_req", int'(walkRequest), 0);
    check("idle_clear_pulse", int'(walkPressPulse), 0);

    // Glitch rejection: 3-cycle highs with 1-cycle gaps
    p = 0; r = 0;
    for (int k = 0; k < 5; k++) begin
      int pp;
      int rr;
      walkButton = 1'b1;
      run(3, pp, rr);
      p += pp; r += rr;
      walkButton = 1'b0;
      run(1, pp, rr);
      p += pp; r += rr;
    end
    begin
      int pp;
      int rr;
      run(8, pp, rr);
      p += pp; r += rr;
    end
    check("glitch_no_pulse", p, 0);
    check("glitch_no_req", r, 0);

    // Simultaneous set and clear
    walkButton = 1'b1;
    run(7, p, r);
    check("sim_req_set", int'(walkRequest), 1);
    walkButton = 1'b0;
    run(10, p, r);
    check("sim_req_kept", int'(walkRequest), 1);
    walkButton = 1'b1;
    run(6, p, r);
    check("sim_pre_pulse", p, 0);
    walkClear = 1'b1;
    tick();
    walkClear = 1'b0;
    check("sim_req_wins", int'(walkRequest), 1);
    check("sim_pulse", int'(walkPressPulse), 1);
    tick();
    check("sim_pulse_drop", int'(walkPressPulse), 0);
    check("sim_req_after", int'(walkRequest), 1);
    walkButton = 1'b0;
    run(10, p, r);
    walkClear = 1'b1;
    tick();
    walkClear = 1'b0;
    check("sim_final_clear", int'(walkRequest), 0);

    // Sensor bounce then hold
    sensor = 1'b0;
    run(10, p, r);
    check("sens_low", int'(sensorStable), 0);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      sensor = (k % 2 == 0) ? 1'b1 : 1'b0;
      for (int j = 0; j < 2; j++) begin
        tick();
        if (sensorStable !== 1'b0) seen++;
      end
    end
    sensor = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (sensorStable !== 1'b0) seen++;
    end
    check("sens_bounce_rejected", seen, 0);
    tick();
    check("sens_hold_rise", int'(sensorStable), 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sensorStable !== 1'b1) seen++;
    end
    check("sens_stays_high", seen, 0);

    // Reset mid-debounce with button still high
    walkButton = 1'b1;
    run(3, p, r);
    reset = 1'b1;
    tick();
    check("mid_rst_req", int'(walkRequest), 0);
    check("mid_rst_pulse", int'(walkPressPulse), 0);
    check("mid_rst_sensor", int'(sensorStable), 0);
    reset = 1'b0;
    run(6, p, r);
    check("mid_rst_no_early_req", r, 0);
    tick();
    check("mid_rst_req_edge6", int'(walkRequest), 1);
    check("mid_rst_pulse_edge6", int'(walkPressPulse), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/walk_sensor_conditioner.md
# walk_sensor_conditioner

Input conditioning stage that sits directly upstream of the traffic-light controller FSM. It synchronises and debounces the raw pedestrian `walkButton` and side-street `sensor` pins, then latches a walk request until the controller acknowledges it. The controller sees only clean, level-stable `sensorStable` and `walkRequest` signals. It returns a one-cycle `walkClear` when it enters its pedestrian-walk state.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept an input change (10 ms at 100 MHz). Must be >= 2.
- `CNT_W`, default 20: debounce counter width. Must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `walkButton` in 1: raw, asynchronous pedestrian button, active-high.
- `sensor` in 1: raw, asynchronous side-street vehicle sensor, active-high.
- `walkClear` in 1: one-cycle acknowledge pulse from the controller; clears the latched request.
- `walkRequest` out 1: latched pedestrian request, held until cleared.
- `walkPressPulse` out 1: one-cycle pulse for each accepted button press.
- `sensorStable` out 1: debounced sensor level.

## Operation
- **Synchroniser:** each raw input passes through a 2-FF synchroniser (`s1`, `s2`). Debouncing uses `s2` only.
- **Debounce, per input:** holds a `stable` register and a counter `cnt`.
  - `s2 == stable`: `cnt <= 0`.
  - `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2` and `cnt <= 0`.
  - Otherwise: `cnt <= cnt + 1`.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles restarts the count, so `stable` does not change.
  - `cnt` never exceeds `DEBOUNCE_CYCLES-1`; no wrap is possible.
- **Edge detect:** `btnStable_d` is a one-cycle delayed copy of the button's `stable`. A press is `stable & ~btnStable_d`. A release generates nothing.
- **Walk latch** (registered; evaluated in this priority order):
  - press this cycle: `walkRequest <= 1` and `walkPressPulse <= 1`. Set wins over a simultaneous `walkClear`, so a press is never lost.
  - else `walkClear`: `walkRequest <= 0`.
  - else `walkRequest` holds.
  - `walkPressPulse` is 0 on every cycle without a press.
- **Repeated presses:** a further press while `walkRequest == 1` is idempotent. It still produces `walkPressPulse`.
- **Sensor output:** `sensorStable` equals the sensor's debounced `stable` register. It has no latch or edge logic.
- **`walkClear` while idle:** when `walkRequest == 0`, `walkClear` has no effect.
- **Held inputs:** a button held high indefinitely produces exactly one press.
- **Reset:** the following all go to 0: `s1`, `s2`, `stable`, `cnt`, `btnStable_d`, `walkRequest`, `walkPressPulse`.
  - A reset mid-debounce discards the partial count.
  - An input still high after reset must debounce again before it is accepted.

## Timing
- **Output reset values:** `walkRequest = 0`, `walkPressPulse = 0`, `sensorStable = 0`.
- **Sensor latency:** let edge 0 be the first `clk` edge that samples a new raw level, with the level held afterwards.
  - `s2` updates at edge 1.
  - `stable`, and therefore `sensorStable`, updates at edge 1 + `DEBOUNCE_CYCLES`.
- **Walk latency:** `walkRequest` and `walkPressPulse` assert at edge 2 + `DEBOUNCE_CYCLES`. `walkPressPulse` deasserts on the following edge.
- **Clear latency:** `walkRequest` falls on the edge after the `walkClear` cycle (one-cycle latency).
- **Combinational paths:** none from any input to any output; all outputs are registered.

## Structure
- **Package `tl_pkg`:**
  - `DEBOUNCE_CYCLES_DEFAULT`.
  - Shared constants for 1 s tick timing, so the clock divider and this block agree on the clock frequency (`CLK_HZ = 100_000_000`).
- **Sub-module `debounce_filter`:** parameters `DEBOUNCE_CYCLES`, `CNT_W`; ports `clk`, `reset`, `in_raw`, `out_stable`. It contains the synchroniser and the counter.
  - Instantiated twice: once for the button, once for the sensor.
  - The edge detect and the walk latch live in the top module.

## Test plan
Bench uses `DEBOUNCE_CYCLES = 4`.
- **Reset values:** assert `reset` for 3 cycles with both raw inputs high → all outputs 0 during reset. After release, `sensorStable` rises exactly 5 edges after the first sampling edge.
- **Clean press:** `walkButton` high for 20 cycles → `walkRequest` and a single `walkPressPulse` at edge 6. Release gives no pulse. `walkRequest` stays 1 until `walkClear` and falls on the next edge.
- **Glitch rejection:** pulse `walkButton` high for 3 cycles, repeated 5 times with 1-cycle gaps → `walkRequest` stays 0 and `walkPressPulse` never fires.
- **Simultaneous set and clear:** `walkRequest = 1`; a new accepted press lands in the same cycle as `walkClear` → `walkRequest` remains 1 and `walkPressPulse = 1`.
- **Sensor bounce:** toggle `sensor` 1-0-1-0 every 2 cycles, then hold 1 → `sensorStable` rises only 5 edges after the final hold begins and stays 1 thereafter.
- **Reset mid-debounce:** raise the button, assert `reset` at edge 3 for 1 cycle with the button still high → no request during reset. The request appears 6 edges after the first post-reset sampling edge.
